// File: rtl/load_buffer.sv
// load_buffer: holds in-flight loads from dispatch until their result is
// broadcast on the CDB. Addresses come from the ALU broadcast; each READY
// load is checked against older stores in the store queue and either takes
// forwarded store data or reads the D$.
module load_buffer #(
   parameter int WAYS  = 2,
   parameter int LBSZ  = 8,
   parameter int LSQSZ = 8,
   parameter int ROB   = 32,
   parameter int PRF   = 64
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           except_i,
   input  logic [WAYS-1:0]                enable_i,
   input  logic [2*WAYS-1:0]              size_i,
   input  logic [WAYS*$clog2(PRF)-1:0]    dest_PRF_idx_i,
   input  logic [WAYS*$clog2(ROB)-1:0]    ROB_idx_i,
   input  logic [WAYS*LSQSZ-1:0]          older_st_mask_i,
   input  logic [WAYS*$clog2(ROB)-1:0]    ALU_ROB_idx_i,
   input  logic [WAYS-1:0]                ALU_is_valid_i,
   input  logic [WAYS*16-1:0]             ALU_data_i,
   input  logic [LSQSZ-1:0]               sq_out_valid_i,
   input  logic [LSQSZ-1:0]               sq_out_addr_valid_i,
   input  logic [LSQSZ*16-1:0]            sq_out_addr_i,
   input  logic [LSQSZ*2-1:0]             sq_out_size_i,
   input  logic [LSQSZ-1:0]               sq_out_data_valid_i,
   input  logic [LSQSZ*64-1:0]            sq_out_data_i,
   input  logic [$clog2(LSQSZ)-1:0]       sq_head_i,
   input  logic                           sq_commit_i,
   output logic                           rd_req_o,
   output logic [15:0]                    rd_addr_o,
   output logic [1:0]                     rd_size_o,
   output logic [$clog2(LBSZ)-1:0]        rd_tag_o,
   input  logic                           rd_gnt_i,
   input  logic                           rd_resp_valid_i,
   input  logic [$clog2(LBSZ)-1:0]        rd_resp_tag_i,
   input  logic [63:0]                    rd_resp_data_i,
   output logic                           cdb_req_o,
   output logic [$clog2(PRF)-1:0]         cdb_PRF_idx_o,
   output logic [$clog2(ROB)-1:0]         cdb_ROB_idx_o,
   output logic [63:0]                    cdb_data_o,
   input  logic                           cdb_gnt_i,
   output logic [$clog2(LBSZ):0]          num_free_o
);

   localparam int LBW  = $clog2(LBSZ);
   localparam int SQW  = $clog2(LSQSZ);
   localparam int ROBW = $clog2(ROB);
   localparam int PRFW = $clog2(PRF);

   typedef enum logic [2:0] {EMPTY, WAIT_ADDR, READY, ISSUED, DONE} state_e;

   state_e             state_q [LBSZ];
   state_e             state_d [LBSZ];
   logic [1:0]         size_q  [LBSZ];
   logic [1:0]         size_d  [LBSZ];
   logic [PRFW-1:0]    prf_q   [LBSZ];
   logic [PRFW-1:0]    prf_d   [LBSZ];
   logic [ROBW-1:0]    rob_q   [LBSZ];
   logic [ROBW-1:0]    rob_d   [LBSZ];
   logic [15:0]        addr_q  [LBSZ];
   logic [15:0]        addr_d  [LBSZ];
   logic [LSQSZ-1:0]   mask_q  [LBSZ];
   logic [LSQSZ-1:0]   mask_d  [LBSZ];
   logic [63:0]        data_q  [LBSZ];
   logic [63:0]        data_d  [LBSZ];
   logic [LBW:0]       num_free_q;
   logic [LBW:0]       num_free_d;

   logic [LBSZ-1:0]    fwd;
   logic [LBSZ-1:0]    clear;
   logic [63:0]        fwd_data [LBSZ];
   logic               iss_found;
   logic [LBW-1:0]     iss_idx;
   logic               cdb_found;
   logic [LBW-1:0]     cdb_idx;

   // Keep only the bytes covered by the access size; upper bits read as zero.
   function automatic logic [63:0] zext(input logic [63:0] d, input logic [1:0] sz);
      case (sz)
         2'd0:    zext = {56'd0, d[7:0]};
         2'd1:    zext = {48'd0, d[15:0]};
         2'd2:    zext = {32'd0, d[31:0]};
         default: zext = d;
      endcase
   endfunction

   // Returns {hit, addr} for the ALU way broadcasting this ROB index.
   function automatic logic [16:0] alu_lookup(input logic [WAYS-1:0]      vld,
                                              input logic [WAYS*ROBW-1:0] robs,
                                              input logic [WAYS*16-1:0]   data,
                                              input logic [ROBW-1:0]      rob);
      alu_lookup = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (vld[w] && robs[w*ROBW +: ROBW] == rob) begin
            alu_lookup = {1'b1, data[w*16 +: 16]};
         end
      end
   endfunction

   // Store check: find the youngest older store on the same doubleword and decide forward/stall/clear.
   always_comb begin : store_check
      logic           stall;
      logic           have;
      logic [SQW-1:0] best_j;
      logic [SQW-1:0] best_age;
      logic [SQW-1:0] age;
      stall    = 1'b0;
      have     = 1'b0;
      best_j   = '0;
      best_age = '0;
      age      = '0;
      for (int i = 0; i < LBSZ; i++) begin
         stall       = 1'b0;
         have        = 1'b0;
         best_j      = '0;
         best_age    = '0;
         fwd[i]      = 1'b0;
         clear[i]    = 1'b0;
         fwd_data[i] = '0;
         for (int j = 0; j < LSQSZ; j++) begin
            // Distance from the SQ head gives program order across wraparound.
            age = SQW'(j) - sq_head_i;
            if (mask_q[i][j] && sq_out_valid_i[j]) begin
               if (!sq_out_addr_valid_i[j]) begin
                  stall = 1'b1;
               end else if (sq_out_addr_i[j*16+3 +: 13] == addr_q[i][15:3]) begin
                  if (!have || age > best_age) begin
                     have     = 1'b1;
                     best_j   = SQW'(j);
                     best_age = age;
                  end
               end
            end
         end
         if (state_q[i] == READY && !stall) begin
            if (!have) begin
               clear[i] = 1'b1;
            end else if (sq_out_data_valid_i[best_j] &&
                         sq_out_addr_i[best_j*16 +: 16] == addr_q[i] &&
                         sq_out_size_i[best_j*2 +: 2] == size_q[i]) begin
               fwd[i]      = 1'b1;
               fwd_data[i] = zext(sq_out_data_i[best_j*64 +: 64], size_q[i]);
            end
         end
      end
   end

   // Lowest-index selection of the D$ issuer and the CDB driver.
   always_comb begin
      iss_found = 1'b0;
      iss_idx   = '0;
      cdb_found = 1'b0;
      cdb_idx   = '0;
      for (int i = LBSZ - 1; i >= 0; i--) begin
         if (clear[i]) begin
            iss_found = 1'b1;
            iss_idx   = LBW'(i);
         end
         if (state_q[i] == DONE) begin
            cdb_found = 1'b1;
            cdb_idx   = LBW'(i);
         end
      end
   end

   assign rd_req_o      = iss_found;
   assign rd_addr_o     = iss_found ? addr_q[iss_idx] : '0;
   assign rd_size_o     = iss_found ? size_q[iss_idx] : '0;
   assign rd_tag_o      = iss_found ? iss_idx : '0;
   assign cdb_req_o     = cdb_found;
   assign cdb_PRF_idx_o = cdb_found ? prf_q[cdb_idx] : '0;
   assign cdb_ROB_idx_o = cdb_found ? rob_q[cdb_idx] : '0;
   assign cdb_data_o    = cdb_found ? data_q[cdb_idx] : '0;
   assign num_free_o    = num_free_q;

   // Next state: per-entry transitions, dispatch allocation, then mask aging.
   always_comb begin : next_state
      logic [LBSZ-1:0] taken;
      logic            found;
      logic [LBW-1:0]  slot;
      logic [16:0]     hit;
      taken   = '0;
      found   = 1'b0;
      slot    = '0;
      hit     = '0;
      state_d = state_q;
      size_d  = size_q;
      prf_d   = prf_q;
      rob_d   = rob_q;
      addr_d  = addr_q;
      mask_d  = mask_q;
      data_d  = data_q;

      for (int i = 0; i < LBSZ; i++) begin
         case (state_q[i])
            WAIT_ADDR: begin
               hit = alu_lookup(ALU_is_valid_i, ALU_ROB_idx_i, ALU_data_i, rob_q[i]);
               if (hit[16]) begin
                  state_d[i] = READY;
                  addr_d[i]  = hit[15:0];
               end
            end
            READY: begin
               if (fwd[i]) begin
                  state_d[i] = DONE;
                  data_d[i]  = fwd_data[i];
               end else if (iss_found && iss_idx == LBW'(i) && rd_gnt_i) begin
                  state_d[i] = ISSUED;
               end
            end
            ISSUED: begin
               if (rd_resp_valid_i && rd_resp_tag_i == LBW'(i)) begin
                  state_d[i] = DONE;
                  data_d[i]  = zext(rd_resp_data_i, size_q[i]);
               end
            end
            DONE: begin
               if (cdb_found && cdb_idx == LBW'(i) && cdb_gnt_i) begin
                  state_d[i] = EMPTY;
               end
            end
            default: ;
         endcase
      end

      // Free slots come from registered state so a slot freed this cycle waits a cycle.
      for (int w = 0; w < WAYS; w++) begin
         if (enable_i[w]) begin
            found = 1'b0;
            slot  = '0;
            for (int i = 0; i < LBSZ; i++) begin
               if (!found && state_q[i] == EMPTY && !taken[i]) begin
                  found = 1'b1;
                  slot  = LBW'(i);
               end
            end
            if (found) begin
               taken[slot]  = 1'b1;
               size_d[slot] = size_i[w*2 +: 2];
               prf_d[slot]  = dest_PRF_idx_i[w*PRFW +: PRFW];
               rob_d[slot]  = ROB_idx_i[w*ROBW +: ROBW];
               mask_d[slot] = older_st_mask_i[w*LSQSZ +: LSQSZ];
               hit = alu_lookup(ALU_is_valid_i, ALU_ROB_idx_i, ALU_data_i,
                                ROB_idx_i[w*ROBW +: ROBW]);
               if (hit[16]) begin
                  state_d[slot] = READY;
                  addr_d[slot]  = hit[15:0];
               end else begin
                  state_d[slot] = WAIT_ADDR;
               end
            end
         end
      end

      if (sq_commit_i) begin
         for (int i = 0; i < LBSZ; i++) begin
            mask_d[i][sq_head_i] = 1'b0;
         end
      end

      num_free_d = '0;
      for (int i = 0; i < LBSZ; i++) begin
         if (state_d[i] == EMPTY) begin
            num_free_d = num_free_d + 1'b1;
         end
      end
   end

   // Control state: flushed by reset or an exception.
   always_ff @(posedge clock) begin
      if (reset || except_i) begin
         for (int i = 0; i < LBSZ; i++) begin
            state_q[i] <= EMPTY;
         end
         num_free_q <= (LBW+1)'(LBSZ);
      end else begin
         state_q    <= state_d;
         num_free_q <= num_free_d;
      end
   end

   // Entry payload: only meaningful while the entry is not EMPTY, so never reset.
   always_ff @(posedge clock) begin
      size_q <= size_d;
      prf_q  <= prf_d;
      rob_q  <= rob_d;
      addr_q <= addr_d;
      mask_q <= mask_d;
      data_q <= data_d;
   end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer with a CDB scoreboard and a simple D$ driver.
module tb_load_buffer;
   localparam int LSQSZ = 8;

   logic         clock;
   logic         reset;
   logic         except_r;
   logic [1:0]   enable;
   logic [3:0]   size;
   logic [11:0]  dest_prf;
   logic [9:0]   rob_idx;
   logic [15:0]  older_mask;
   logic [9:0]   alu_rob;
   logic [1:0]   alu_vld;
   logic [31:0]  alu_data;
   logic [7:0]   sq_valid;
   logic [7:0]   sq_addr_valid;
   logic [7:0]   sq_data_valid;
   logic [15:0]  sq_addr [LSQSZ];
   logic [1:0]   sq_size [LSQSZ];
   logic [63:0]  sq_data [LSQSZ];
   logic [127:0] sq_addr_bus;
   logic [15:0]  sq_size_bus;
   logic [511:0] sq_data_bus;
   logic [2:0]   sq_head;
   logic         sq_commit;
   logic         rd_req;
   logic [15:0]  rd_addr;
   logic [1:0]   rd_size;
   logic [2:0]   rd_tag;
   logic         rd_gnt;
   logic         rd_gnt_en;
   logic         rd_resp_valid;
   logic [2:0]   rd_resp_tag;
   logic [63:0]  rd_resp_data;
   logic         cdb_req;
   logic [5:0]   cdb_prf;
   logic [4:0]   cdb_rob;
   logic [63:0]  cdb_data;
   logic         cdb_gnt;
   logic         gnt_en;
   logic [3:0]   num_free;

   typedef struct packed {
      logic [5:0]  prf;
      logic [4:0]  rob;
      logic [63:0] data;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          tests;
   int          fails;
   int          rd_total;
   int          iss_total;
   int          base;
   logic [63:0] exp_fill [8];
   int          resp_order [8];

   always_comb begin
      for (int j = 0; j < LSQSZ; j++) begin
         sq_addr_bus[j*16 +: 16] = sq_addr[j];
         sq_size_bus[j*2 +: 2]   = sq_size[j];
         sq_data_bus[j*64 +: 64] = sq_data[j];
      end
   end

   assign rd_gnt  = rd_req & rd_gnt_en;
   assign cdb_gnt = gnt_en;

   load_buffer dut (
      .clock               (clock),
      .reset               (reset),
      .except_i            (except_r),
      .enable_i            (enable),
      .size_i              (size),
      .dest_PRF_idx_i      (dest_prf),
      .ROB_idx_i           (rob_idx),
      .older_st_mask_i     (older_mask),
      .ALU_ROB_idx_i       (alu_rob),
      .ALU_is_valid_i      (alu_vld),
      .ALU_data_i          (alu_data),
      .sq_out_valid_i      (sq_valid),
      .sq_out_addr_valid_i (sq_addr_valid),
      .sq_out_addr_i       (sq_addr_bus),
      .sq_out_size_i       (sq_size_bus),
      .sq_out_data_valid_i (sq_data_valid),
      .sq_out_data_i       (sq_data_bus),
      .sq_head_i           (sq_head),
      .sq_commit_i         (sq_commit),
      .rd_req_o            (rd_req),
      .rd_addr_o           (rd_addr),
      .rd_size_o           (rd_size),
      .rd_tag_o            (rd_tag),
      .rd_gnt_i            (rd_gnt),
      .rd_resp_valid_i     (rd_resp_valid),
      .rd_resp_tag_i       (rd_resp_tag),
      .rd_resp_data_i      (rd_resp_data),
      .cdb_req_o           (cdb_req),
      .cdb_PRF_idx_o       (cdb_prf),
      .cdb_ROB_idx_o       (cdb_rob),
      .cdb_data_o          (cdb_data),
      .cdb_gnt_i           (cdb_gnt),
      .num_free_o          (num_free)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor, D$ activity counters and the dispatch overflow guard.
   always @(negedge clock) begin
      if (cdb_req && cdb_gnt) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL cdb_unexpected: got rob %0d, expected no result", cdb_rob);
         end else begin
            mon_e = sb.pop_front();
            check("cdb_prf", 64'(cdb_prf), 64'(mon_e.prf));
            check("cdb_rob", 64'(cdb_rob), 64'(mon_e.rob));
            check("cdb_data", cdb_data, mon_e.data);
         end
      end
      if (rd_req) rd_total++;
      if (rd_req && rd_gnt) iss_total++;
      if (!reset && ($countones(enable) > int'(num_free))) begin
         fails++;
         $display("FAIL dispatch_overflow: enabled %0d, num_free %0d", $countones(enable), num_free);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      enable  = '0;
      alu_vld = '0;
   endtask

   task automatic clear_sq();
      sq_valid      = '0;
      sq_addr_valid = '0;
      sq_data_valid = '0;
      sq_head       = '0;
      sq_commit     = 1'b0;
      for (int j = 0; j < LSQSZ; j++) begin
         sq_addr[j] = '0;
         sq_size[j] = '0;
         sq_data[j] = '0;
      end
   endtask

   task automatic set_store(input int j, input logic [15:0] a, input logic [1:0] sz,
                            input logic dv, input logic [63:0] d);
      sq_valid[j]      = 1'b1;
      sq_addr_valid[j] = 1'b1;
      sq_addr[j]       = a;
      sq_size[j]       = sz;
      sq_data_valid[j] = dv;
      sq_data[j]       = d;
   endtask

   task automatic set_way(input int w, input logic [1:0] sz, input logic [5:0] prf,
                          input logic [4:0] rob, input logic [7:0] mask,
                          input logic alu, input logic [15:0] a);
      enable[w]            = 1'b1;
      size[w*2 +: 2]       = sz;
      dest_prf[w*6 +: 6]   = prf;
      rob_idx[w*5 +: 5]    = rob;
      older_mask[w*8 +: 8] = mask;
      alu_vld[w]           = alu;
      alu_rob[w*5 +: 5]    = rob;
      alu_data[w*16 +: 16] = a;
   endtask

   task automatic push(input logic [5:0] prf, input logic [4:0] rob, input logic [63:0] d);
      exp_t e;
      e.prf  = prf;
      e.rob  = rob;
      e.data = d;
      sb.push_back(e);
   endtask

   task automatic wait_sb_empty(input int max, input string name);
      int n;
      n = 0;
      while (sb.size() != 0 && n < max) begin
         tick();
         n++;
      end
      check(name, 64'(sb.size()), 64'd0);
   endtask

   task automatic respond(input logic [2:0] tag, input logic [63:0] d);
      rd_resp_valid = 1'b1;
      rd_resp_tag   = tag;
      rd_resp_data  = d;
      tick();
      rd_resp_valid = 1'b0;
   endtask

   initial begin
      tests = 0; fails = 0; rd_total = 0; iss_total = 0; base = 0;
      exp_fill[0] = 64'h0000_0000_0000_0000;
      exp_fill[1] = 64'h0000_0000_0000_EE01;
      exp_fill[2] = 64'h0000_0000_CCDD_EE02;
      exp_fill[3] = 64'h8899_AABB_CCDD_EE03;
      exp_fill[4] = 64'h0000_0000_0000_0004;
      exp_fill[5] = 64'h0000_0000_0000_EE05;
      exp_fill[6] = 64'h0000_0000_CCDD_EE06;
      exp_fill[7] = 64'h8899_AABB_CCDD_EE07;
      resp_order  = '{5, 2, 7, 0, 3, 6, 1, 4};

      reset = 1'b1; except_r = 1'b0;
      enable = '0; size = '0; dest_prf = '0; rob_idx = '0; older_mask = '0;
      alu_rob = '0; alu_vld = '0; alu_data = '0;
      rd_gnt_en = 1'b1; rd_resp_valid = 1'b0; rd_resp_tag = '0; rd_resp_data = '0;
      gnt_en = 1'b1;
      clear_sq();
      tick();
      tick();
      @(negedge clock);
      check("reset_rd_req", 64'(rd_req), 64'd0);
      check("reset_cdb_req", 64'(cdb_req), 64'd0);
      check("reset_rd_addr", 64'(rd_addr), 64'd0);
      check("reset_cdb_data", cdb_data, 64'd0);
      check("reset_num_free", 64'(num_free), 64'd8);
      tick();
      reset = 1'b0;

      // Forwarding: full match against SQ slot 2, no D$ read.
      set_store(2, 16'h0040, 2'd3, 1'b1, 64'hDEAD_BEEF_0000_1111);
      base = rd_total;
      set_way(0, 2'd3, 6'd5, 5'd3, 8'b0000_0100, 1'b1, 16'h0040);
      push(6'd5, 5'd3, 64'hDEAD_BEEF_0000_1111);
      tick();
      clear_inputs();
      wait_sb_empty(10, "fwd_complete");
      check("fwd_no_rd_req", 64'(rd_total - base), 64'd0);
      @(negedge clock);
      check("fwd_num_free", 64'(num_free), 64'd8);
      tick();
      clear_sq();

      // Address stall: older store without an address blocks the load.
      sq_valid[1] = 1'b1;
      set_way(0, 2'd3, 6'd6, 5'd4, 8'b0000_0010, 1'b1, 16'h0040);
      tick();
      clear_inputs();
      @(negedge clock);
      check("addr_stall_rd_req_a", 64'(rd_req), 64'd0);
      tick();
      @(negedge clock);
      check("addr_stall_rd_req_b", 64'(rd_req), 64'd0);
      tick();
      sq_addr_valid[1] = 1'b1;
      sq_addr[1]       = 16'h0080;
      sq_size[1]       = 2'd3;
      @(negedge clock);
      check("addr_release_rd_req", 64'(rd_req), 64'd1);
      check("addr_release_rd_addr", 64'(rd_addr), 64'h40);
      check("addr_release_rd_size", 64'(rd_size), 64'd3);
      check("addr_release_rd_tag", 64'(rd_tag), 64'd0);
      tick();
      push(6'd6, 5'd4, 64'h0123_4567_89AB_CDEF);
      respond(3'd0, 64'h0123_4567_89AB_CDEF);
      wait_sb_empty(10, "addr_stall_complete");
      clear_sq();

      // Partial overlap: word store at 0x40 vs word load at 0x44 stalls until the store commits.
      sq_head = 3'd2;
      set_store(2, 16'h0040, 2'd2, 1'b1, 64'h0000_0000_1111_2222);
      set_way(0, 2'd2, 6'd7, 5'd5, 8'b0000_0100, 1'b1, 16'h0044);
      tick();
      clear_inputs();
      @(negedge clock);
      check("partial_rd_req_a", 64'(rd_req), 64'd0);
      check("partial_cdb_req", 64'(cdb_req), 64'd0);
      tick();
      sq_commit = 1'b1;
      @(negedge clock);
      check("partial_rd_req_commit_cycle", 64'(rd_req), 64'd0);
      tick();
      sq_commit = 1'b0;
      @(negedge clock);
      check("partial_release_rd_req", 64'(rd_req), 64'd1);
      check("partial_release_rd_addr", 64'(rd_addr), 64'h44);
      check("partial_release_rd_size", 64'(rd_size), 64'd2);
      tick();
      push(6'd7, 5'd5, 64'h0000_0000_AAAA_BBBB);
      respond(3'd0, 64'hFFFF_FFFF_AAAA_BBBB);
      wait_sb_empty(10, "partial_complete");
      clear_sq();

      // Wraparound: head 6, slot 1 is younger than slot 7; two loads in one dispatch.
      sq_head = 3'd6;
      set_store(7, 16'h0040, 2'd3, 1'b1, 64'hA0A0_A0A0_A0A0_A0A0);
      set_store(1, 16'h0040, 2'd3, 1'b1, 64'hB1B1_B1B1_B1B1_B1B1);
      base = rd_total;
      set_way(0, 2'd3, 6'd8, 5'd6, 8'h82, 1'b1, 16'h0040);
      set_way(1, 2'd3, 6'd9, 5'd7, 8'h80, 1'b1, 16'h0040);
      push(6'd8, 5'd6, 64'hB1B1_B1B1_B1B1_B1B1);
      push(6'd9, 5'd7, 64'hA0A0_A0A0_A0A0_A0A0);
      tick();
      clear_inputs();
      wait_sb_empty(10, "wrap_complete");
      check("wrap_no_rd_req", 64'(rd_total - base), 64'd0);
      clear_sq();

      // Fill with 8 loads, out-of-order responses, CDB held off for 3 cycles.
      gnt_en = 1'b0;
      base = iss_total;
      for (int c = 0; c < 4; c++) begin
         for (int w = 0; w < 2; w++) begin
            set_way(w, 2'((2*c + w) % 4), 6'(16 + 2*c + w), 5'(8 + 2*c + w), 8'h00,
                    1'b1, 16'(16'h0100 + 8*(2*c + w)));
         end
         tick();
      end
      clear_inputs();
      for (int k = 0; k < 8; k++) push(6'(16 + k), 5'(8 + k), exp_fill[k]);
      @(negedge clock);
      check("fill_num_free", 64'(num_free), 64'd0);
      for (int n = 0; n < 30 && (iss_total - base) < 8; n++) tick();
      check("fill_all_issued", 64'(iss_total - base), 64'd8);
      tick();
      for (int r = 0; r < 8; r++) begin
         respond(3'(resp_order[r]), 64'h8899_AABB_CCDD_EE00 | 64'(resp_order[r]));
      end
      for (int h = 0; h < 3; h++) begin
         @(negedge clock);
         check("backpressure_cdb_req", 64'(cdb_req), 64'd1);
         check("backpressure_cdb_rob", 64'(cdb_rob), 64'd8);
         tick();
      end
      gnt_en = 1'b1;
      wait_sb_empty(20, "fill_drain");
      @(negedge clock);
      check("drain_num_free", 64'(num_free), 64'd8);
      tick();

      // Reset mid-operation with three live loads, then a late ALU broadcast.
      gnt_en = 1'b0;
      rd_gnt_en = 1'b0;
      set_way(0, 2'd3, 6'd30, 5'd20, 8'h00, 1'b1, 16'h0200);
      set_way(1, 2'd3, 6'd31, 5'd21, 8'h00, 1'b0, 16'h0000);
      tick();
      clear_inputs();
      set_way(0, 2'd3, 6'd32, 5'd22, 8'h00, 1'b0, 16'h0000);
      tick();
      clear_inputs();
      @(negedge clock);
      check("pre_reset_rd_req", 64'(rd_req), 64'd1);
      check("pre_reset_rd_addr", 64'(rd_addr), 64'h200);
      check("pre_reset_num_free", 64'(num_free), 64'd5);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      alu_vld[0] = 1'b1;
      alu_rob[4:0] = 5'd21;
      alu_data[15:0] = 16'h0300;
      @(negedge clock);
      check("midreset_rd_req", 64'(rd_req), 64'd0);
      check("midreset_cdb_req", 64'(cdb_req), 64'd0);
      check("midreset_rd_addr", 64'(rd_addr), 64'd0);
      check("midreset_num_free", 64'(num_free), 64'd8);
      tick();
      clear_inputs();
      @(negedge clock);
      check("late_alu_rd_req", 64'(rd_req), 64'd0);
      check("late_alu_num_free", 64'(num_free), 64'd8);
      tick();

      // Except flush with a read outstanding; a stale response must be ignored.
      gnt_en = 1'b1;
      rd_gnt_en = 1'b1;
      set_way(0, 2'd3, 6'd10, 5'd9, 8'h00, 1'b1, 16'h0500);
      tick();
      clear_inputs();
      @(negedge clock);
      check("except_rd_req", 64'(rd_req), 64'd1);
      check("except_rd_tag", 64'(rd_tag), 64'd0);
      tick();
      @(negedge clock);
      check("except_issued_rd_req", 64'(rd_req), 64'd0);
      check("except_issued_num_free", 64'(num_free), 64'd7);
      tick();
      except_r = 1'b1;
      tick();
      except_r = 1'b0;
      respond(3'd0, 64'h55);
      @(negedge clock);
      check("stale_resp_cdb_req", 64'(cdb_req), 64'd0);
      check("except_num_free", 64'(num_free), 64'd8);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
